trap_sequencer: RTL and testbench
=================================

// Module: trap_sequencer
// PURPOSE
//  Multi-cycle controller that sequences trap entry and MRET around the write-back stage and CSR file.
//  Accepts exception reports, external interrupt, MRET from WB; stalls/flushes pipeline, waits for memory drain,
//  issues one CSR save strobe (mepc/mcause/mtval, MIE clear), then redirects fetch PC. Sits between WB, CSR file, fetch.
// PARAMETERS
//  XLEN           32  datapath width
//  DRAIN_TIMEOUT  16  max cycles waiting in FLUSH for mem_busy_i to drop; range 1..255
// PORTS
//  clk_i          in   1     clock
//  rst_i          in   1     synchronous, active-high reset
//  exc_valid_i    in   1     WB instruction raised an exception this cycle
//  exc_cause_i    in   4     exception code (0,2,4,6 used)
//  exc_pc_i       in   XLEN  PC of faulting instruction
//  exc_tval_i     in   XLEN  faulting address / instruction
//  mret_i         in   1     WB retiring MRET
//  retire_i       in   1     WB retiring a normal instruction this cycle
//  next_pc_i      in   XLEN  PC following the retiring instruction
//  irq_ext_i      in   1     machine external interrupt, level
//  mstatus_mie_i  in   1     mstatus.MIE from CSR file
//  mie_meie_i     in   1     mie.MEIE from CSR file
//  mtvec_i        in   XLEN  mtvec from CSR file
//  mepc_i         in   XLEN  mepc from CSR file
//  mem_busy_i     in   1     outstanding data-memory access
//  stall_o        out  1     freeze pipeline
//  flush_o        out  1     kill all instructions younger than WB
//  trap_we_o      out  1     one-cycle CSR save strobe
//  mcause_o       out  XLEN  mcause write data (bit XLEN-1 = interrupt)
//  mepc_o         out  XLEN  mepc write data, bits[1:0] forced 0
//  mtval_o        out  XLEN  mtval write data (0 for interrupts)
//  mie_clr_o      out  1     CSR file: MPIE<=MIE, MIE<=0 (coincides with trap_we_o)
//  mie_restore_o  out  1     CSR file: MIE<=MPIE, MPIE<=1
//  pc_redirect_o  out  1     one-cycle fetch redirect
//  pc_target_o    out  XLEN  redirect target
//  drain_timeout_o out 1     sticky; set when FLUSH exits via timeout, cleared by reset only
// BEHAVIOUR
//  Reset: state IDLE; every output 0; captured cause/pc/tval 0; timer 0. Reset in any state aborts sequence.
//  States IDLE, FLUSH, SAVE, REDIRECT. Acceptance only in IDLE; priority exc_valid_i > interrupt > mret_i.
//  Interrupt pending = irq_ext_i & mstatus_mie_i & mie_meie_i & retire_i; mepc = next_pc_i, mcause = 0x8000000B.
//  IDLE->FLUSH on accept: capture cause/pc/tval (tval 0 for irq), kind {EXC,IRQ,MRET}; timer<=0.
//  FLUSH: stall_o=1, flush_o=1. Exit when mem_busy_i==0 or timer==DRAIN_TIMEOUT-1 (timeout sets drain_timeout_o).
//   EXC/IRQ -> SAVE; MRET -> REDIRECT. Timer increments each FLUSH cycle, saturating.
//  SAVE (1 cycle): stall_o=1, trap_we_o=1, mie_clr_o=1, mcause_o/mepc_o/mtval_o driven from capture regs; ->REDIRECT.
//  REDIRECT (1 cycle): stall_o=1, pc_redirect_o=1; target = {mtvec_i[XLEN-1:2],2'b00} for traps,
//   {mepc_i[XLEN-1:2],2'b00} for MRET with mie_restore_o=1; ->IDLE. Total trap latency accept->redirect >= 3 cycles.
//  mcause_o/mepc_o/mtval_o hold 0 outside SAVE. Requests while not IDLE are ignored (bench asserts none arrive).
//  Back-to-back: new request in the cycle after REDIRECT is accepted normally.
// CONFIGURATION
//  TRAP_VECTORED_EN defined: if mtvec_i[1:0]==2'b01 and kind==IRQ, target = base + 4*cause[3:0] (0x2C offset
//   for external irq); exceptions always use base. Undefined: mtvec_i[1:0] ignored, all traps go to base.
// STRUCTURE
//  Shared package trap_pkg: state encoding, kind encoding, cause constants (ILLEGAL=2, INST_MIS=0, LD_MIS=4,
//   ST_MIS=6, MEI=11), INT_BIT position.
//  One sub-module: trap_drain_timer (load/enable/saturating counter, timeout flag), parameterised by DRAIN_TIMEOUT.
// TESTING
//  exc_valid_i, cause=2, pc=0x100, tval=0x0000_0073, mem_busy_i=0, mtvec=0x200 -> FLUSH 1 cyc, SAVE with mcause=2,
//   mepc=0x100, mtval=0x73, mie_clr_o; REDIRECT to 0x200.
//  irq_ext_i=1, MIE=MEIE=1, retire_i, next_pc=0x44, mtvec=0x301 -> mcause=0x8000000B, mtval=0; target 0x32C
//   with TRAP_VECTORED_EN, 0x300 without.
//  mret_i, mepc=0x105 -> no trap_we_o; REDIRECT to 0x104 with mie_restore_o=1.
//  exc_valid_i with mem_busy_i held 1 -> FLUSH exactly DRAIN_TIMEOUT cycles, drain_timeout_o=1 stays set.
//  exc_valid_i and irq pending same cycle -> exception taken; irq taken on later retire after MIE restore.
//  rst_i asserted in SAVE -> next cycle IDLE, all outputs 0, no redirect issued.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared encodings for the trap sequencer: FSM states, request kinds and cause codes.
package trap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_SAVE     = 2'd2,
        ST_REDIRECT = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        KIND_EXC  = 2'd0,
        KIND_IRQ  = 2'd1,
        KIND_MRET = 2'd2
    } kind_e;

    localparam logic [3:0] CAUSE_INST_MIS = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL  = 4'd2;
    localparam logic [3:0] CAUSE_LD_MIS   = 4'd4;
    localparam logic [3:0] CAUSE_ST_MIS   = 4'd6;
    localparam logic [3:0] CAUSE_MEI      = 4'd11;

    // Interrupt flag position in mcause for the default 32-bit datapath.
    localparam int INT_BIT = 31;

endpackage

// File: rtl/trap_drain_timer.sv
// Saturating cycle counter that bounds how long the sequencer waits for memory to drain.
module trap_drain_timer #(
    parameter int DRAIN_TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic timeout_o
);

    localparam logic [7:0] LAST = 8'(DRAIN_TIMEOUT - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = '0;
        end else if (en_i && (count_q != LAST)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign timeout_o = (count_q == LAST);

endmodule

// File: rtl/trap_sequencer.sv
// Trap entry / MRET sequencer: IDLE -> FLUSH -> SAVE -> REDIRECT with registered outputs.
// Optional macro TRAP_VECTORED_EN enables vectored interrupt targets when mtvec[1:0]==2'b01.
module trap_sequencer
    import trap_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int DRAIN_TIMEOUT = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            exc_valid_i,
    input  logic [3:0]      exc_cause_i,
    input  logic [XLEN-1:0] exc_pc_i,
    input  logic [XLEN-1:0] exc_tval_i,
    input  logic            mret_i,
    input  logic            retire_i,
    input  logic [XLEN-1:0] next_pc_i,
    input  logic            irq_ext_i,
    input  logic            mstatus_mie_i,
    input  logic            mie_meie_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    input  logic            mem_busy_i,
    output logic            stall_o,
    output logic            flush_o,
    output logic            trap_we_o,
    output logic [XLEN-1:0] mcause_o,
    output logic [XLEN-1:0] mepc_o,
    output logic [XLEN-1:0] mtval_o,
    output logic            mie_clr_o,
    output logic            mie_restore_o,
    output logic            pc_redirect_o,
    output logic [XLEN-1:0] pc_target_o,
    output logic            drain_timeout_o
);

    state_e          state_q;
    kind_e           kind_q;
    logic [XLEN-1:0] cause_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] tval_q;

    logic            irq_pending;
    logic            timer_expired;
    logic            flush_done;
    logic [XLEN-1:0] irq_cause;
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] trap_target;

    assign irq_pending = irq_ext_i & mstatus_mie_i & mie_meie_i & retire_i;
    assign flush_done  = !mem_busy_i || timer_expired;
    assign trap_base   = {mtvec_i[XLEN-1:2], 2'b00};

    always_comb begin
        irq_cause          = '0;
        irq_cause[XLEN-1]  = 1'b1;
        irq_cause[3:0]     = CAUSE_MEI;
    end

`ifdef TRAP_VECTORED_EN
    always_comb begin
        trap_target = trap_base;
        if ((mtvec_i[1:0] == 2'b01) && (kind_q == KIND_IRQ)) begin
            trap_target = trap_base + {{(XLEN-6){1'b0}}, cause_q[3:0], 2'b00};
        end
    end
`else
    assign trap_target = trap_base;
`endif

    // Counter is held at zero while idle, so every accepted request starts a fresh drain window.
    trap_drain_timer #(
        .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
    ) u_drain_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (state_q == ST_IDLE),
        .en_i      (state_q == ST_FLUSH),
        .timeout_o (timer_expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= ST_IDLE;
            kind_q          <= KIND_EXC;
            cause_q         <= '0;
            pc_q            <= '0;
            tval_q          <= '0;
            stall_o         <= 1'b0;
            flush_o         <= 1'b0;
            trap_we_o       <= 1'b0;
            mcause_o        <= '0;
            mepc_o          <= '0;
            mtval_o         <= '0;
            mie_clr_o       <= 1'b0;
            mie_restore_o   <= 1'b0;
            pc_redirect_o   <= 1'b0;
            pc_target_o     <= '0;
            drain_timeout_o <= 1'b0;
        end else begin
            // NOTE: one-cycle strobes and CSR data default low here and are raised only by the state that owns them.
            trap_we_o     <= 1'b0;
            mie_clr_o     <= 1'b0;
            mie_restore_o <= 1'b0;
            pc_redirect_o <= 1'b0;
            mcause_o      <= '0;
            mepc_o        <= '0;
            mtval_o       <= '0;
            pc_target_o   <= '0;

            case (state_q)
                ST_IDLE: begin
                    if (exc_valid_i || irq_pending || mret_i) begin
                        state_q <= ST_FLUSH;
                        stall_o <= 1'b1;
                        flush_o <= 1'b1;
                    end
                    if (exc_valid_i) begin
                        kind_q  <= KIND_EXC;
                        cause_q <= {{(XLEN-4){1'b0}}, exc_cause_i};
                        pc_q    <= {exc_pc_i[XLEN-1:2], 2'b00};
                        tval_q  <= exc_tval_i;
                    end else if (irq_pending) begin
                        kind_q  <= KIND_IRQ;
                        cause_q <= irq_cause;
                        pc_q    <= {next_pc_i[XLEN-1:2], 2'b00};
                        tval_q  <= '0;
                    end else if (mret_i) begin
                        kind_q  <= KIND_MRET;
                        cause_q <= '0;
                        pc_q    <= '0;
                        tval_q  <= '0;
                    end
                end

                ST_FLUSH: begin
                    if (flush_done) begin
                        flush_o <= 1'b0;
                        if (mem_busy_i) begin
                            drain_timeout_o <= 1'b1;
                        end
                        if (kind_q == KIND_MRET) begin
                            state_q       <= ST_REDIRECT;
                            pc_redirect_o <= 1'b1;
                            pc_target_o   <= {mepc_i[XLEN-1:2], 2'b00};
                            mie_restore_o <= 1'b1;
                        end else begin
                            state_q   <= ST_SAVE;
                            trap_we_o <= 1'b1;
                            mie_clr_o <= 1'b1;
                            mcause_o  <= cause_q;
                            mepc_o    <= pc_q;
                            mtval_o   <= tval_q;
                        end
                    end
                end

                ST_SAVE: begin
                    state_q       <= ST_REDIRECT;
                    pc_redirect_o <= 1'b1;
                    pc_target_o   <= trap_target;
                end

                ST_REDIRECT: begin
                    state_q <= ST_IDLE;
                    stall_o <= 1'b0;
                end

                default: begin
                    state_q <= ST_IDLE;
                    stall_o <= 1'b0;
                    flush_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: table of trap/MRET requests plus reset and non-acceptance sequences.
module tb_trap_sequencer;

    localparam int XLEN = 32;
    localparam int DT   = 16;

`ifdef TRAP_VECTORED_EN
    localparam logic [31:0] IRQ_TGT = 32'h0000_032C;
`else
    localparam logic [31:0] IRQ_TGT = 32'h0000_0300;
`endif

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            exc_valid_i;
    logic [3:0]      exc_cause_i;
    logic [XLEN-1:0] exc_pc_i;
    logic [XLEN-1:0] exc_tval_i;
    logic            mret_i;
    logic            retire_i;
    logic [XLEN-1:0] next_pc_i;
    logic            irq_ext_i;
    logic            mstatus_mie_i;
    logic            mie_meie_i;
    logic [XLEN-1:0] mtvec_i;
    logic [XLEN-1:0] mepc_i;
    logic            mem_busy_i;
    logic            stall_o;
    logic            flush_o;
    logic            trap_we_o;
    logic [XLEN-1:0] mcause_o;
    logic [XLEN-1:0] mepc_o;
    logic [XLEN-1:0] mtval_o;
    logic            mie_clr_o;
    logic            mie_restore_o;
    logic            pc_redirect_o;
    logic [XLEN-1:0] pc_target_o;
    logic            drain_timeout_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    trap_sequencer #(
        .XLEN          (XLEN),
        .DRAIN_TIMEOUT (DT)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .exc_valid_i     (exc_valid_i),
        .exc_cause_i     (exc_cause_i),
        .exc_pc_i        (exc_pc_i),
        .exc_tval_i      (exc_tval_i),
        .mret_i          (mret_i),
        .retire_i        (retire_i),
        .next_pc_i       (next_pc_i),
        .irq_ext_i       (irq_ext_i),
        .mstatus_mie_i   (mstatus_mie_i),
        .mie_meie_i      (mie_meie_i),
        .mtvec_i         (mtvec_i),
        .mepc_i          (mepc_i),
        .mem_busy_i      (mem_busy_i),
        .stall_o         (stall_o),
        .flush_o         (flush_o),
        .trap_we_o       (trap_we_o),
        .mcause_o        (mcause_o),
        .mepc_o          (mepc_o),
        .mtval_o         (mtval_o),
        .mie_clr_o       (mie_clr_o),
        .mie_restore_o   (mie_restore_o),
        .pc_redirect_o   (pc_redirect_o),
        .pc_target_o     (pc_target_o),
        .drain_timeout_o (drain_timeout_o)
    );

    typedef struct {
        logic        exc;
        logic [3:0]  cause;
        logic [31:0] pc;
        logic [31:0] tval;
        logic        mret;
        logic        irq;
        logic        retire;
        logic [31:0] next_pc;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        int          busy;
        int          exp_fc;
        int          exp_we;
        logic [31:0] exp_mcause;
        logic [31:0] exp_mepc;
        logic [31:0] exp_mtval;
        logic [31:0] exp_target;
        logic        exp_restore;
        logic        exp_to;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ctl_bits();
        return {25'd0, stall_o, flush_o, trap_we_o, mie_clr_o, mie_restore_o,
                pc_redirect_o, drain_timeout_o};
    endfunction

    task automatic clear_req();
        exc_valid_i = 1'b0;
        mret_i      = 1'b0;
        irq_ext_i   = 1'b0;
        retire_i    = 1'b0;
    endtask

    // Starts just after a rising edge with the DUT idle; returns just after the edge that ends REDIRECT.
    task automatic run_vec(input vec_t v, input int idx);
        int          fc = 0;
        int          we = 0;
        bit          done = 0;
        bit          bad_hold = 0;
        logic [31:0] c_mcause = '0, c_mepc = '0, c_mtval = '0, tgt = '0;
        logic        c_clr = 1'b0, c_stall_save = 1'b0, rsto = 1'b0, to = 1'b0, stall_r = 1'b0;

        exc_valid_i = v.exc;
        exc_cause_i = v.cause;
        exc_pc_i    = v.pc;
        exc_tval_i  = v.tval;
        mret_i      = v.mret;
        irq_ext_i   = v.irq;
        retire_i    = v.retire;
        next_pc_i   = v.next_pc;
        mtvec_i     = v.mtvec;
        mepc_i      = v.mepc;
        mem_busy_i  = (v.busy > 0);
        @(posedge clk_i);
        #1;
        clear_req();

        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk_i);
            if (flush_o) begin
                fc++;
                mem_busy_i = (fc < v.busy);
            end else begin
                mem_busy_i = 1'b0;
            end
            if (trap_we_o) begin
                we++;
                c_mcause     = mcause_o;
                c_mepc       = mepc_o;
                c_mtval      = mtval_o;
                c_clr        = mie_clr_o;
                c_stall_save = stall_o;
            end else if ((mcause_o | mepc_o | mtval_o) != 32'd0) begin
                bad_hold = 1;
            end
            if (pc_redirect_o) begin
                done    = 1;
                tgt     = pc_target_o;
                rsto    = mie_restore_o;
                to      = drain_timeout_o;
                stall_r = stall_o;
            end
        end

        check($sformatf("v%0d redirect_seen", idx), 32'(done), 32'd1);
        check($sformatf("v%0d flush_cycles", idx), 32'(fc), 32'(v.exp_fc));
        check($sformatf("v%0d trap_we_count", idx), 32'(we), 32'(v.exp_we));
        check($sformatf("v%0d mcause", idx), c_mcause, v.exp_mcause);
        check($sformatf("v%0d mepc", idx), c_mepc, v.exp_mepc);
        check($sformatf("v%0d mtval", idx), c_mtval, v.exp_mtval);
        check($sformatf("v%0d mie_clr", idx), 32'(c_clr), 32'(v.exp_we));
        check($sformatf("v%0d save_stall", idx), 32'(c_stall_save), 32'(v.exp_we));
        check($sformatf("v%0d csr_data_hold0", idx), 32'(bad_hold), 32'd0);
        check($sformatf("v%0d target", idx), tgt, v.exp_target);
        check($sformatf("v%0d mie_restore", idx), 32'(rsto), 32'(v.exp_restore));
        check($sformatf("v%0d redirect_stall", idx), 32'(stall_r), 32'd1);
        check($sformatf("v%0d drain_timeout", idx), 32'(to), 32'(v.exp_to));
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int seen;

        // exc cause pc tval mret irq ret next_pc mtvec mepc busy | fc we mcause mepc mtval target restore to
        vecs[0] = '{1'b1, 4'd2, 32'h100, 32'h73, 1'b0, 1'b0, 1'b0, 32'h0, 32'h200, 32'h0, 0,
                    1, 1, 32'h2, 32'h100, 32'h73, 32'h200, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h44, 32'h301, 32'h0, 0,
                    1, 1, 32'h8000_000B, 32'h44, 32'h0, IRQ_TGT, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 4'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h301, 32'h105, 0,
                    1, 0, 32'h0, 32'h0, 32'h0, 32'h104, 1'b1, 1'b0};
        // exception and pending interrupt in the same cycle; low pc bits dropped; vectored mode ignored
        vecs[3] = '{1'b1, 4'd4, 32'h202, 32'h1235, 1'b0, 1'b1, 1'b1, 32'h206, 32'h301, 32'h105, 3,
                    3, 1, 32'h4, 32'h200, 32'h1235, 32'h300, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 4'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h301, 32'h206, 0,
                    1, 0, 32'h0, 32'h0, 32'h0, 32'h204, 1'b1, 1'b0};
        // memory drains exactly on the last allowed cycle: not a timeout
        vecs[5] = '{1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h208, 32'h301, 32'h206, DT,
                    DT, 1, 32'h8000_000B, 32'h208, 32'h0, IRQ_TGT, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 4'd6, 32'h300, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0, 32'h400, 32'h206, 1000,
                    DT, 1, 32'h6, 32'h300, 32'hDEAD_BEEF, 32'h400, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 4'd0, 32'h10, 32'h12, 1'b0, 1'b0, 1'b0, 32'h0, 32'h400, 32'h206, 0,
                    1, 1, 32'h0, 32'h10, 32'h12, 32'h400, 1'b0, 1'b1};

        rst_i         = 1'b1;
        clear_req();
        exc_cause_i   = '0;
        exc_pc_i      = '0;
        exc_tval_i    = '0;
        next_pc_i     = '0;
        mstatus_mie_i = 1'b1;
        mie_meie_i    = 1'b1;
        mtvec_i       = '0;
        mepc_i        = '0;
        mem_busy_i    = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("reset ctl", ctl_bits(), 32'd0);
        check("reset data", mcause_o | mepc_o | mtval_o | pc_target_o, 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        // Interrupt without a retiring instruction, or with MIE clear, must not be taken.
        seen = 0;
        irq_ext_i = 1'b1;
        retire_i  = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) begin
                retire_i      = 1'b1;
                mstatus_mie_i = 1'b0;
            end
            @(negedge clk_i);
            if (stall_o) seen++;
        end
        check("irq not taken", 32'(seen), 32'd0);
        clear_req();
        mstatus_mie_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Reset while SAVE is active aborts the sequence without a redirect.
        exc_valid_i = 1'b1;
        exc_cause_i = 4'd2;
        exc_pc_i    = 32'h500;
        exc_tval_i  = 32'h77;
        mtvec_i     = 32'h200;
        @(posedge clk_i);
        #1;
        clear_req();
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            @(negedge clk_i);
            if (trap_we_o) seen = 1;
        end
        check("rst_save reached", 32'(seen), 32'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rst_save ctl", ctl_bits(), 32'd0);
        check("rst_save data", mcause_o | mepc_o | mtval_o | pc_target_o, 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            if (pc_redirect_o || stall_o) seen++;
        end
        check("rst_save no redirect", 32'(seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
